// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: datapath widths, the fetch-queue entry layout and the
// instruction-format one-hot encodings.
package decode_pkg;

    localparam int unsigned AddrWidth  = 64;
    localparam int unsigned InstrWidth = 32;
    localparam int unsigned PidWidth   = 20;
    localparam int unsigned TidWidth   = 16;
    localparam int unsigned MajIdWidth = 64;

    typedef struct packed {
        logic [InstrWidth-1:0] instruction;
        logic [AddrWidth-1:0]  address;
        logic [PidWidth-1:0]   pid;
        logic [TidWidth-1:0]   tid;
        logic [MajIdWidth-1:0] maj_id;
    } fetch_entry_t;

    localparam int unsigned FetchEntryWidth = $bits(fetch_entry_t);

    // Instruction-format one-hots produced by decode stage 1.
    localparam int unsigned FmtWidth = 6;
    localparam logic [FmtWidth-1:0] FmtR = 6'b000001;
    localparam logic [FmtWidth-1:0] FmtI = 6'b000010;
    localparam logic [FmtWidth-1:0] FmtS = 6'b000100;
    localparam logic [FmtWidth-1:0] FmtB = 6'b001000;
    localparam logic [FmtWidth-1:0] FmtU = 6'b010000;
    localparam logic [FmtWidth-1:0] FmtJ = 6'b100000;

endpackage

// File: rtl/fetch_queue_storage.sv
// Depth x EntryWidth register array for the fetch queue: one synchronous write port and one
// asynchronous read port. Contents are not reset; validity is tracked by the owner's pointers.
module fetch_queue_storage #(
    parameter int unsigned Depth      = 4,
    parameter int unsigned PtrWidth   = 2,
    parameter int unsigned EntryWidth = 8
) (
    input  logic                  clock_i,
    input  logic                  wr_en_i,
    input  logic [PtrWidth-1:0]   wr_ptr_i,
    input  logic [EntryWidth-1:0] wr_data_i,
    input  logic [PtrWidth-1:0]   rd_ptr_i,
    output logic [EntryWidth-1:0] rd_data_o
);

    logic [EntryWidth-1:0] mem_q [Depth];

    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/fetch_instruction_queue.sv
// Fetch-to-decode instruction queue: tags each accepted word with a major ID, buffers it and
// presents one per cycle. Define FETCH_QUEUE_BYPASS_EN to forward words into an empty queue.
module fetch_instruction_queue
    import decode_pkg::*;
#(
    parameter int unsigned addressWidth            = AddrWidth,
    parameter int unsigned instructionWidth        = InstrWidth,
    parameter int unsigned PidSize                 = PidWidth,
    parameter int unsigned TidSize                 = TidWidth,
    parameter int unsigned instructionCounterWidth = MajIdWidth,
    parameter int unsigned QueueDepth              = 4,
    parameter int unsigned QueuePtrWidth           = 2
) (
    input  logic                                 clock_i,
    input  logic                                 resetn_i,
    input  logic                                 fetchValid_i,
    input  logic [0:instructionWidth-1]          instruction_i,
    input  logic [0:addressWidth-1]              instructionAddress_i,
    input  logic [0:PidSize-1]                   instructionPid_i,
    input  logic [0:TidSize-1]                   instructionTid_i,
    input  logic                                 flush_i,
    input  logic                                 stall_i,
    output logic                                 fetchStall_o,
    output logic                                 outputEnable_o,
    output logic [0:instructionWidth-1]          instruction_o,
    output logic [0:addressWidth-1]              instructionAddress_o,
    output logic [0:PidSize-1]                   instructionPid_o,
    output logic [0:TidSize-1]                   instructionTid_o,
    output logic [0:instructionCounterWidth-1]   instructionMajId_o,
    output logic [0:QueuePtrWidth]               queueCount_o
);

    localparam int unsigned EntryWidth =
        instructionWidth + addressWidth + PidSize + TidSize + instructionCounterWidth;
    localparam logic [QueuePtrWidth:0] FullCount = (QueuePtrWidth+1)'(QueueDepth);

    logic [QueuePtrWidth-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [QueuePtrWidth:0]             count_q, count_d;
    logic [instructionCounterWidth-1:0] maj_id_q, maj_id_d;
    logic                               out_en_q, out_en_d;
    logic [0:instructionWidth-1]        instr_q, instr_d;
    logic [0:addressWidth-1]            addr_q, addr_d;
    logic [0:PidSize-1]                 pid_q, pid_d;
    logic [0:TidSize-1]                 tid_q, tid_d;
    logic [0:instructionCounterWidth-1] maj_out_q, maj_out_d;

    logic [EntryWidth-1:0]              wr_entry, rd_entry;
    logic [0:instructionWidth-1]        ent_instr;
    logic [0:addressWidth-1]            ent_addr;
    logic [0:PidSize-1]                 ent_pid;
    logic [0:TidSize-1]                 ent_tid;
    logic [0:instructionCounterWidth-1] ent_maj;

    logic full, push, push_fifo, pop, bypass;

    assign full = (count_q == FullCount);
    assign push = fetchValid_i && !full && !flush_i;
    assign pop  = !flush_i && !stall_i && (count_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = push && !stall_i && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word goes straight to the output registers and never occupies a slot.
    assign push_fifo = push && !bypass;

    assign wr_entry = {instruction_i, instructionAddress_i, instructionPid_i, instructionTid_i,
                       maj_id_q};
    assign {ent_instr, ent_addr, ent_pid, ent_tid, ent_maj} = rd_entry;

    fetch_queue_storage #(
        .Depth      (QueueDepth),
        .PtrWidth   (QueuePtrWidth),
        .EntryWidth (EntryWidth)
    ) u_storage (
        .clock_i   (clock_i),
        .wr_en_i   (push_fifo),
        .wr_ptr_i  (wr_ptr_q),
        .wr_data_i (wr_entry),
        .rd_ptr_i  (rd_ptr_q),
        .rd_data_o (rd_entry)
    );

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        maj_id_d  = maj_id_q;
        out_en_d  = out_en_q;
        instr_d   = instr_q;
        addr_d    = addr_q;
        pid_d     = pid_q;
        tid_d     = tid_q;
        maj_out_d = maj_out_q;

        if (flush_i) begin
            // The major ID counter survives a flush so IDs are never reused.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            out_en_d = 1'b0;
        end else begin
            if (push) begin
                maj_id_d = maj_id_q + instructionCounterWidth'(1);
            end
            if (push_fifo) begin
                wr_ptr_d = wr_ptr_q + QueuePtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + QueuePtrWidth'(1);
            end
            unique case ({push_fifo, pop})
                2'b10:   count_d = count_q + (QueuePtrWidth+1)'(1);
                2'b01:   count_d = count_q - (QueuePtrWidth+1)'(1);
                default: count_d = count_q;
            endcase

            if (!stall_i) begin
                if (pop) begin
                    out_en_d  = 1'b1;
                    instr_d   = ent_instr;
                    addr_d    = ent_addr;
                    pid_d     = ent_pid;
                    tid_d     = ent_tid;
                    maj_out_d = ent_maj;
                end else if (bypass) begin
                    out_en_d  = 1'b1;
                    instr_d   = instruction_i;
                    addr_d    = instructionAddress_i;
                    pid_d     = instructionPid_i;
                    tid_d     = instructionTid_i;
                    maj_out_d = maj_id_q;
                end else begin
                    out_en_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            maj_id_q  <= '0;
            out_en_q  <= 1'b0;
            instr_q   <= '0;
            addr_q    <= '0;
            pid_q     <= '0;
            tid_q     <= '0;
            maj_out_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            maj_id_q  <= maj_id_d;
            out_en_q  <= out_en_d;
            instr_q   <= instr_d;
            addr_q    <= addr_d;
            pid_q     <= pid_d;
            tid_q     <= tid_d;
            maj_out_q <= maj_out_d;
        end
    end

    assign fetchStall_o         = full;
    assign outputEnable_o       = out_en_q;
    assign instruction_o        = instr_q;
    assign instructionAddress_o = addr_q;
    assign instructionPid_o     = pid_q;
    assign instructionTid_o     = tid_q;
    assign instructionMajId_o   = maj_out_q;
    assign queueCount_o         = count_q;

endmodule

// File: tb/tb_fetch_instruction_queue.sv
// Directed bench for fetch_instruction_queue; expectations follow FETCH_QUEUE_BYPASS_EN.
module tb_fetch_instruction_queue;

    logic        clock_i = 1'b0;
    logic        resetn_i;
    logic        fetchValid_i;
    logic [0:31] instruction_i;
    logic [0:63] instructionAddress_i;
    logic [0:19] instructionPid_i;
    logic [0:15] instructionTid_i;
    logic        flush_i;
    logic        stall_i;
    logic        fetchStall_o;
    logic        outputEnable_o;
    logic [0:31] instruction_o;
    logic [0:63] instructionAddress_o;
    logic [0:19] instructionPid_o;
    logic [0:15] instructionTid_o;
    logic [0:63] instructionMajId_o;
    logic [0:2]  queueCount_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock_i = ~clock_i;

    fetch_instruction_queue u_dut (
        .clock_i              (clock_i),
        .resetn_i             (resetn_i),
        .fetchValid_i         (fetchValid_i),
        .instruction_i        (instruction_i),
        .instructionAddress_i (instructionAddress_i),
        .instructionPid_i     (instructionPid_i),
        .instructionTid_i     (instructionTid_i),
        .flush_i              (flush_i),
        .stall_i              (stall_i),
        .fetchStall_o         (fetchStall_o),
        .outputEnable_o       (outputEnable_o),
        .instruction_o        (instruction_o),
        .instructionAddress_o (instructionAddress_o),
        .instructionPid_o     (instructionPid_o),
        .instructionTid_o     (instructionTid_o),
        .instructionMajId_o   (instructionMajId_o),
        .queueCount_o         (queueCount_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic do_reset();
        resetn_i     = 1'b0;
        fetchValid_i = 1'b0;
        flush_i      = 1'b0;
        stall_i      = 1'b0;
        repeat (2) @(posedge clock_i);
        #1;
        resetn_i = 1'b1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [63:0] addr,
                         input logic [19:0] pid, input logic [15:0] tid);
        fetchValid_i         = 1'b1;
        instruction_i        = ins;
        instructionAddress_i = addr;
        instructionPid_i     = pid;
        instructionTid_i     = tid;
    endtask

    // Push one word into an empty, unstalled queue and follow it to the outputs and back out.
    task automatic push_empty(input string tag, input logic [31:0] ins, input logic [63:0] addr,
                              input logic [19:0] pid, input logic [15:0] tid,
                              input logic [63:0] exp_maj);
        drive(ins, addr, pid, tid);
        tick();
        fetchValid_i = 1'b0;
`ifndef FETCH_QUEUE_BYPASS_EN
        check({tag, "_cnt_queued"}, 64'(queueCount_o), 64'd1);
        check({tag, "_oe_early"}, 64'(outputEnable_o), 64'd0);
        tick();
`endif
        check({tag, "_oe"}, 64'(outputEnable_o), 64'd1);
        check({tag, "_instr"}, 64'(instruction_o), 64'(ins));
        check({tag, "_addr"}, instructionAddress_o, addr);
        check({tag, "_pid"}, 64'(instructionPid_o), 64'(pid));
        check({tag, "_tid"}, 64'(instructionTid_o), 64'(tid));
        check({tag, "_maj"}, instructionMajId_o, exp_maj);
        check({tag, "_cnt"}, 64'(queueCount_o), 64'd0);
        tick();
        check({tag, "_oe_drop"}, 64'(outputEnable_o), 64'd0);
        check({tag, "_instr_hold"}, 64'(instruction_o), 64'(ins));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state and first push.
        do_reset();
        check("rst_oe", 64'(outputEnable_o), 64'd0);
        check("rst_cnt", 64'(queueCount_o), 64'd0);
        check("rst_full", 64'(fetchStall_o), 64'd0);
        check("rst_maj", instructionMajId_o, 64'd0);
        check("rst_instr", 64'(instruction_o), 64'd0);
        check("rst_addr", instructionAddress_o, 64'd0);
        push_empty("t1", 32'h4800_0010, 64'h1000, 20'd5, 16'd2, 64'd0);

        // Fill under stall, refuse the fifth word, then drain in order.
        do_reset();
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(32'h1000_0000 + 32'(i), 64'h2000 + 64'(4 * i), 20'd1, 16'd1);
            tick();
            check($sformatf("t2_cnt%0d", i), 64'(queueCount_o), 64'((i < 4) ? i + 1 : 4));
            check($sformatf("t2_hold%0d", i), 64'(outputEnable_o), 64'd0);
        end
        check("t2_full", 64'(fetchStall_o), 64'd1);
        fetchValid_i = 1'b0;
        stall_i      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t2_oe%0d", i), 64'(outputEnable_o), 64'd1);
            check($sformatf("t2_maj%0d", i), instructionMajId_o, 64'(i));
            check($sformatf("t2_ins%0d", i), 64'(instruction_o), 64'h1000_0000 + 64'(i));
            check($sformatf("t2_dcnt%0d", i), 64'(queueCount_o), 64'(3 - i));
        end
        check("t2_not_full", 64'(fetchStall_o), 64'd0);
        tick();
        check("t2_empty_oe", 64'(outputEnable_o), 64'd0);
        push_empty("t2_next", 32'h1234_5678, 64'h2100, 20'd9, 16'd8, 64'd4);

        // Streaming: pointers wrap, IDs strictly increase, occupancy stays low.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(32'h2000_0000 + 32'(i), 64'h3000 + 64'(4 * i), 20'd2, 16'd3);
            tick();
`ifdef FETCH_QUEUE_BYPASS_EN
            check($sformatf("t3_oe%0d", i), 64'(outputEnable_o), 64'd1);
            check($sformatf("t3_maj%0d", i), instructionMajId_o, 64'(i));
            check($sformatf("t3_cnt%0d", i), 64'(queueCount_o), 64'd0);
`else
            check($sformatf("t3_oe%0d", i), 64'(outputEnable_o), 64'(i > 0));
            if (i > 0) check($sformatf("t3_maj%0d", i), instructionMajId_o, 64'(i - 1));
            check($sformatf("t3_cnt%0d", i), 64'(queueCount_o), 64'd1);
`endif
        end
        fetchValid_i = 1'b0;
        tick();
`ifdef FETCH_QUEUE_BYPASS_EN
        check("t3_tail_oe", 64'(outputEnable_o), 64'd0);
`else
        check("t3_tail_oe", 64'(outputEnable_o), 64'd1);
        check("t3_tail_maj", instructionMajId_o, 64'd9);
`endif
        check("t3_tail_cnt", 64'(queueCount_o), 64'd0);

        // Flush with a queued backlog and a concurrent push, under stall.
        do_reset();
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(32'h3000_0000 + 32'(i), 64'h4000, 20'd3, 16'd4);
            tick();
        end
        fetchValid_i = 1'b0;
        stall_i      = 1'b0;
        repeat (4) tick();
        check("t4_drained_maj", instructionMajId_o, 64'd3);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h3100_0000 + 32'(i), 64'h4100, 20'd3, 16'd4);
            tick();
        end
        check("t4_cnt3", 64'(queueCount_o), 64'd3);
        check("t4_stall_hold_oe", 64'(outputEnable_o), 64'd1);
        check("t4_stall_hold_maj", instructionMajId_o, 64'd3);
        drive(32'hDEAD_BEEF, 64'h4200, 20'd3, 16'd4);
        flush_i = 1'b1;
        tick();
        flush_i      = 1'b0;
        fetchValid_i = 1'b0;
        stall_i      = 1'b0;
        check("t4_flush_cnt", 64'(queueCount_o), 64'd0);
        check("t4_flush_oe", 64'(outputEnable_o), 64'd0);
        push_empty("t4_next", 32'h3200_0000, 64'h4300, 20'd3, 16'd4, 64'd7);

        // Asynchronous reset mid-stream.
        do_reset();
        push_empty("t5_a", 32'hA5A5_0001, 64'h5000, 20'd6, 16'd7, 64'd0);
        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(32'hA5A5_0002 + 32'(i), 64'h5004, 20'd6, 16'd7);
            tick();
        end
        fetchValid_i = 1'b0;
        check("t5_cnt2", 64'(queueCount_o), 64'd2);
        resetn_i = 1'b0;
        #2;
        check("t5_rst_cnt", 64'(queueCount_o), 64'd0);
        check("t5_rst_oe", 64'(outputEnable_o), 64'd0);
        check("t5_rst_instr", 64'(instruction_o), 64'd0);
        check("t5_rst_addr", instructionAddress_o, 64'd0);
        check("t5_rst_full", 64'(fetchStall_o), 64'd0);
        resetn_i = 1'b1;
        stall_i  = 1'b0;
        push_empty("t5_after", 32'hA5A5_0010, 64'h5100, 20'd6, 16'd7, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_instruction_queue.md
Name: fetch_instruction_queue

Overview:
- Buffering stage between the fetch unit and the format decoder (decode stage 1).
- Accepts fetched instruction words with their address, PID and TID, and assigns each accepted word a unique, monotonically increasing major ID.
- Holds words in a small FIFO and presents one per cycle to the format decoder. The format decoder's enable_i/stall_i semantics apply.
- Absorbs downstream stalls and back-pressures fetch when full; supports pipeline flush.

Parameters:
- addressWidth, 64, instruction address width.
- instructionWidth, 32, fixed 4-byte instruction word.
- PidSize, 20, process ID width.
- TidSize, 16, thread ID width.
- instructionCounterWidth, 64, major ID width.
- QueueDepth, 4, FIFO entries; must be a power of 2 and at least 2.
- QueuePtrWidth, 2, log2(QueueDepth).

Ports:
- clock_i  in  1  single clock, rising edge.
- resetn_i  in  1  asynchronous, active-low reset.
- fetchValid_i  in  1  fetch presents a valid word this cycle.
- instruction_i  in  [0:instructionWidth-1]  instruction word.
- instructionAddress_i  in  [0:addressWidth-1]  instruction address.
- instructionPid_i  in  [0:PidSize-1]  process ID.
- instructionTid_i  in  [0:TidSize-1]  thread ID.
- flush_i  in  1  discard all queued and presented instructions.
- stall_i  in  1  downstream cannot accept; hold outputs.
- fetchStall_o  out  1  queue full; fetch must hold its word.
- outputEnable_o  out  1  output bundle valid; drives the decoder's enable_i.
- instruction_o  out  [0:instructionWidth-1]  instruction word.
- instructionAddress_o  out  [0:addressWidth-1]  instruction address.
- instructionPid_o  out  [0:PidSize-1]  process ID.
- instructionTid_o  out  [0:TidSize-1]  thread ID.
- instructionMajId_o  out  [0:instructionCounterWidth-1]  major ID.
- queueCount_o  out  [0:QueuePtrWidth]  current occupancy, 0..QueueDepth.

Behaviour:
- Reset (resetn_i low, asynchronous): the following are cleared to 0:
  - read/write pointers;
  - occupancy count;
  - major ID counter;
  - outputEnable_o;
  - all data outputs.
  - fetchStall_o reads 0 while in reset.
- fetchStall_o is combinational: 1 exactly when count == QueueDepth.
- Push: on a rising edge with fetchValid_i=1, count<QueueDepth and flush_i=0:
  - write {instruction, address, PID, TID, majId counter} at the write pointer;
  - increment the write pointer and the majId counter.
- Pop/present: on a rising edge with stall_i=0 and flush_i=0:
  - if count>0, load the output registers from the read pointer, set outputEnable_o=1 and increment the read pointer;
  - if count==0, set outputEnable_o=0; data outputs hold their last value.
- stall_i=1 and flush_i=0: all output registers hold and no pop occurs. A push may still occur.
- Simultaneous push and pop: count is unchanged. Entries stay ordered by major ID.
- Full with a pop in the same cycle: the push is still refused, because fetchStall_o depends only on count. Throughput is not required at full.
- Pointers wrap modulo QueueDepth. The majId counter wraps at 2^instructionCounterWidth.
- Latency: a word pushed at edge N appears on the outputs at edge N+1 at the earliest. An empty queue therefore adds one cycle of latency.
- Flush (flush_i=1 at an edge) has priority over push, pop and stall:
  - pointers and count go to 0;
  - outputEnable_o goes to 0;
  - the incoming word is dropped;
  - the majId counter is not reset and not incremented, so IDs are never reused.
- Reset asserted mid-operation: all state clears immediately. After release, the first accepted word gets majId 0.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count==0, stall_i=0, flush_i=0 and fetchValid_i=1, the incoming word goes straight into the output registers with the current majId. outputEnable_o=1, the counter increments, and the FIFO is not written. Empty-queue latency is 0 extra cycles.
- Undefined: there is no bypass and the latency is as above.
- All other rules are identical in both builds.

Decomposition:
- Shared package decode_pkg holds:
  - width constants: address, instruction, PID, TID, major ID;
  - the queue-entry struct typedef;
  - the format one-hot constants used by decode stages.
- One natural sub-module: fetch_queue_storage, a QueueDepth x entry-width register array with a write port and a read port. Pointer, count and control logic live in the top module.

Test Plan:
- Reset release, then push 0x48000010 @ 0x1000 with PID 5 and TID 2 -> one edge later: outputEnable_o=1, instruction_o=0x48000010, instructionMajId_o=0, queueCount_o=0.
- Hold stall_i=1 and push 5 words -> queueCount_o reaches 4, fetchStall_o=1, the 5th word is not accepted, and the outputs hold. Release the stall -> majIds 0..3 emerge in order on consecutive cycles.
- Continuous push with no stall for 10 cycles -> pointers wrap, majIds 0..9 emerge strictly increasing, and count stays ≤1.
- Queue holding 3 entries (majIds 4–6) with flush_i=1 and fetchValid_i=1 at the same edge -> count=0, outputEnable_o=0, the next accepted word gets majId 7.
- Assert resetn_i low asynchronously mid-stream with count=2 -> outputs and count go to 0 before the next edge, and the next accepted word gets majId 0.
- With FETCH_QUEUE_BYPASS_EN defined, push into an empty queue -> outputEnable_o=1 at the same edge. Without the macro, outputEnable_o=1 one edge later.
